fetch_sequencer: RTL

//  Controls the fetch unit. Drives its PC op, issues instruction-memory reads at the current PC, and tags responses with their PC.

---
 rtl/rv32i_pkg.sv | 25 ++
 rtl/fetch_buf.sv | 43 ++++
 rtl/fetch_sequencer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared fetch-side types: PC operation codes, fetch FSM states and buffer entries.
package rv32i_pkg;

  localparam int FETCH_XLEN = 32;

  typedef enum logic [2:0] {
    PC_OP_HOLD = 3'd0,
    PC_OP_INC  = 3'd1,
    PC_OP_IMM  = 3'd2,
    PC_OP_ALU  = 3'd3
  } pc_op_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FLUSH
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buf.sv
// Small FIFO of fetched {pc, inst} entries; flush empties it in one cycle.
module fetch_buf
  import rv32i_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  fetch_entry_t           wr_entry,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_entry;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch control: issues instruction reads at the PC, tags responses, buffers them for decode.
// Optional FETCH_PERF_EN adds fetched / decode-stall counters.
module fetch_sequencer
  import rv32i_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] i_pc_data,
  output pc_op_e          o_pc_op,
  input  logic            i_redirect_valid,
  input  logic            i_redirect_src,
  output logic            o_im_req_valid,
  input  logic            i_im_req_ready,
  output logic [XLEN-1:0] o_im_req_addr,
  input  logic            i_im_rsp_valid,
  input  logic [XLEN-1:0] i_im_rsp_data,
  output logic            o_inst_valid,
  output logic [XLEN-1:0] o_inst_data,
  output logic [XLEN-1:0] o_inst_pc,
`ifdef FETCH_PERF_EN
  output logic [31:0]     o_perf_fetched,
  output logic [31:0]     o_perf_stall,
`endif
  input  logic            i_inst_ready
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e    state;
  fetch_state_e    state_next;
  logic [XLEN-1:0] pc_tag;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            flush;
  logic            accept;
  logic            outstanding;
  fetch_entry_t    head;
  fetch_entry_t    wr_entry;

  assign outstanding   = (state == WAIT) || (state == FLUSH);
  assign accept        = o_im_req_valid && i_im_req_ready;
  assign o_im_req_addr = i_pc_data;
  assign o_inst_valid  = (count != '0);
  assign o_inst_data   = head.inst;
  assign o_inst_pc     = head.pc;
  assign pop           = o_inst_valid && i_inst_ready;
  assign wr_entry      = '{pc: pc_tag, inst: i_im_rsp_data};

  // Redirect wins over everything; a response in the same cycle retires the
  // outstanding read, so only a still-pending read sends us to FLUSH.
  always_comb begin
    state_next     = state;
    o_pc_op        = PC_OP_HOLD;
    o_im_req_valid = 1'b0;
    push           = 1'b0;
    flush          = 1'b0;
    if (i_redirect_valid) begin
      o_pc_op    = i_redirect_src ? PC_OP_ALU : PC_OP_IMM;
      flush      = 1'b1;
      state_next = (outstanding && !i_im_rsp_valid) ? FLUSH : REQ;
    end else begin
      case (state)
        IDLE: state_next = REQ;
        REQ: begin
          o_im_req_valid = (count < CW'(BUF_DEPTH));
          if (o_im_req_valid && i_im_req_ready) begin
            o_pc_op    = PC_OP_INC;
            state_next = WAIT;
          end
        end
        WAIT: begin
          if (i_im_rsp_valid) begin
            push       = 1'b1;
            state_next = REQ;
          end
        end
        FLUSH: begin
          if (i_im_rsp_valid) state_next = REQ;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (accept) pc_tag <= i_pc_data;
  end

  fetch_buf #(
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .flush    (flush),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_perf_fetched <= '0;
      o_perf_stall   <= '0;
    end else begin
      if (push) o_perf_fetched <= o_perf_fetched + 32'd1;
      if (i_inst_ready && !o_inst_valid) o_perf_stall <= o_perf_stall + 32'd1;
    end
  end
`endif

endmodule
